// File: rtl/microsequencer_if.sv
// Signal bundle between a microsequencer and its controlling pipeline.
// No handshake: every input is sampled on each rising clock edge and every output is valid each cycle.
interface microsequencer_if #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 4,
  parameter int NCOND       = 8
);
  localparam int SEL_W = $clog2(NCOND);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic [2:0]        op;
  logic [ADDR_W-1:0] d_in;
  logic [ADDR_W-1:0] r_in;
  logic [3:0]        or_in;
  logic              case_en;
  logic [NCOND-1:0]  cond_in;
  logic [SEL_W-1:0]  cond_sel;
  logic              cond_pol;
  logic              hold;
  logic [ADDR_W-1:0] uc_address;
  logic              stack_empty;
  logic              stack_full;
  logic              stack_err;
  logic [LVL_W-1:0]  stack_level;

  modport master (
    output op, d_in, r_in, or_in, case_en, cond_in, cond_sel, cond_pol, hold,
    input  uc_address, stack_empty, stack_full, stack_err, stack_level
  );

  modport slave (
    input  op, d_in, r_in, or_in, case_en, cond_in, cond_sel, cond_pol, hold,
    output uc_address, stack_empty, stack_full, stack_err, stack_level
  );
endinterface

// File: rtl/microsequencer.sv
// Microcode next-address sequencer with conditional branching, case merge,
// an address register and a bounded subroutine return stack.
module microsequencer #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 4,
  parameter int NCOND       = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  microsequencer_if.slave      bus
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_CONT = 3'd0,
    OP_JUMP = 3'd1,
    OP_JSR  = 3'd2,
    OP_RTS  = 3'd3,
    OP_BRC  = 3'd4,
    OP_JSRC = 3'd5,
    OP_LDAR = 3'd6,
    OP_JAR  = 3'd7
  } op_e;

  logic [ADDR_W-1:0] r_uc_address;
  logic [ADDR_W-1:0] r_ar;
  logic [LVL_W-1:0]  r_level;
  logic              r_err;
  logic [ADDR_W-1:0] r_stack [0:(1<<IDX_W)-1];

  logic [ADDR_W-1:0] w_upc;
  logic              w_cond;
  logic              w_empty;
  logic              w_full;
  logic [IDX_W-1:0]  w_top_idx;
  logic [IDX_W-1:0]  w_push_idx;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_next;
  logic              w_push;
  logic              w_pop;
  logic              w_ld_ar;

  assign w_upc      = r_uc_address + 1'b1;
  assign w_cond     = bus.cond_in[bus.cond_sel] ^ bus.cond_pol;
  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LVL_W'(STACK_DEPTH));
  assign w_top_idx  = IDX_W'(r_level - 1'b1);
  assign w_push_idx = IDX_W'(r_level);

  always_comb begin
    w_target = w_upc;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_ld_ar  = 1'b0;
    case (op_e'(bus.op))
      OP_CONT: w_target = w_upc;
      OP_JUMP: w_target = bus.d_in;
      OP_JSR: begin
        w_target = bus.d_in;
        w_push   = 1'b1;
      end
      OP_RTS: begin
        // Underflow returns to address 0 so runaway microcode restarts cleanly.
        w_target = w_empty ? '0 : r_stack[w_top_idx];
        w_pop    = 1'b1;
      end
      OP_BRC: w_target = w_cond ? bus.d_in : w_upc;
      OP_JSRC: begin
        w_target = w_cond ? bus.d_in : w_upc;
        w_push   = w_cond;
      end
      OP_LDAR: begin
        w_target = w_upc;
        w_ld_ar  = 1'b1;
      end
      OP_JAR: w_target = r_ar;
      default: w_target = w_upc;
    endcase
    w_next = bus.case_en ? (w_target | {{(ADDR_W-4){1'b0}}, bus.or_in}) : w_target;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_uc_address <= '0;
      r_ar         <= '0;
      r_level      <= '0;
      r_err        <= 1'b0;
    end else if (!bus.hold) begin
      r_uc_address <= w_next;
      if (w_ld_ar) r_ar <= bus.r_in;
      if (w_push) begin
        if (w_full) r_err   <= 1'b1;
        else        r_level <= r_level + 1'b1;
      end
      if (w_pop) begin
        if (w_empty) r_err   <= 1'b1;
        else         r_level <= r_level - 1'b1;
      end
    end
  end

  // Stack contents need no reset; the level alone defines what is valid.
  always_ff @(posedge clock) begin
    if (!reset && !bus.hold && w_push && !w_full) r_stack[w_push_idx] <= w_upc;
  end

  assign bus.uc_address  = r_uc_address;
  assign bus.stack_level = r_level;
  assign bus.stack_err   = r_err;
  assign bus.stack_empty = w_empty;
  assign bus.stack_full  = w_full;
endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 Parameter ADDR_W, default 11, microcode address width in bits.
REQ-002 Parameter STACK_DEPTH, default 4, subroutine stack entries (>=1).
REQ-003 Parameter NCOND, default 8, number of condition inputs (power of two, >=2).
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 op  input  3  next-address operation (encodings in REQ-016).
REQ-008 d_in  input  ADDR_W  pipeline direct branch address.
REQ-009 r_in  input  ADDR_W  address-register load value (FBus-style source).
REQ-010 or_in  input  4  case bits, ORed into next address bits [3:0] when case_en=1.
REQ-011 case_en  input  1  enables or_in merge.
REQ-012 cond_in  input  NCOND  condition vector; cond_sel  input  clog2(NCOND)  selects one bit; cond_pol  input  1  1 = invert selected bit.
REQ-013 hold  input  1  stall: all state held.
REQ-014 uc_address  output  ADDR_W  current registered microcode ROM address.
REQ-015 stack_empty, stack_full, stack_err  output  1 each; stack_level  output  clog2(STACK_DEPTH+1)  entries in use.

Function
REQ-016 op encodings: 0 CONT (uPC); 1 JUMP (d_in); 2 JSR (push uPC, d_in); 3 RTS (pop, target = popped value); 4 BRC (cond ? d_in : uPC); 5 JSRC (cond ? JSR : CONT); 6 LDAR (AR <= r_in, next = uPC); 7 JAR (AR).
REQ-017 uPC = uc_address + 1, modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
REQ-018 cond = cond_in[cond_sel] XOR cond_pol, combinational, same cycle.
REQ-019 Next address = selected target OR {0, or_in} when case_en=1, else the selected target; the OR applies to every op, including RTS and JAR.
REQ-020 uc_address loads the next address on each rising edge with hold=0; latency is one clock from op to new uc_address.
REQ-021 hold=1: uc_address, AR, stack, stack_level and stack_err are unchanged; op is ignored.
REQ-022 The pushed value is uPC of the current address, before the OR merge.
REQ-023 Stack is LIFO with the top at index stack_level-1; push increments stack_level and pop decrements it.
REQ-024 Push with stack_full=1: the push is discarded, the stack is unchanged, stack_err sets, and the jump to d_in is still taken.
REQ-025 RTS with stack_empty=1: the target is 0 (before the OR merge), stack_level stays 0, and stack_err sets.
REQ-026 stack_err is sticky; only reset clears it.
REQ-027 stack_empty = (stack_level==0); stack_full = (stack_level==STACK_DEPTH); both are combinational from stack_level.
REQ-028 JSRC/BRC with cond=0: identical to CONT, with no stack change.
REQ-029 AR changes only on LDAR; JAR does not modify AR.

Reset
REQ-030 reset=1 at a rising edge: uc_address=0, AR=0, stack_level=0, stack_err=0; stack contents are don't-care.
REQ-031 Reset has priority over hold and op.
REQ-032 Reset mid-subroutine discards all stack entries; a following RTS is an underflow (REQ-025).
REQ-033 One cycle after reset release with op=CONT, uc_address=1.

Verification
REQ-034 Reset, then 3 cycles of CONT -> uc_address 0,1,2,3; JUMP d_in=0x7FF then CONT -> 0x7FF then 0x000 (wrap).
REQ-035 At 0x100: JSR d_in=0x200 -> 0x200, level 1; nested JSR d_in=0x300 from 0x200 -> level 2; RTS -> 0x201; RTS -> 0x101, empty.
REQ-036 Five JSRs from empty (STACK_DEPTH=4) -> stack_full after 4, fifth jumps but stack_err=1, level 4; four RTS return in LIFO order; fifth RTS -> address 0.
REQ-037 BRC cond_sel=3, cond_in=0x08, cond_pol=0 -> d_in taken; cond_pol=1 -> uPC; JSRC with cond false -> no push.
REQ-038 JUMP d_in=0x120, case_en=1, or_in=0x5 -> 0x125; LDAR r_in=0x0A0 at 0x050 -> 0x051; JAR -> 0x0A0.
REQ-039 hold=1 for 3 cycles during JSR -> no change; reset asserted with hold=1 -> all state cleared.
